multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multicycle RV32I core. Each cycle it drives the datapath strobes: PC write, memory address source, memory write, IR write, mux selects, ALU operation, immediate format and register write. It sits directly upstream of the datapath and sequences every instruction through fetch, decode, execute and writeback. Inputs are instruction fields taken from the instruction register plus the ALU flags.

## Interface
- No parameters.
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`, `carry`, `sign`, `overflow`  in  1 each  ALU flags for the current `src_a`/`src_b`. `carry` is the carry-out of a+~b+1, so 1 means a>=b unsigned.
- `pc_write`  out  1  PC register loads `result`.
- `adr_src`  out  1  0=PC, 1=`result` as the memory address.
- `mem_write`  out  1  data memory write enable.
- `ir_write`  out  1  instruction register and old_pc load.
- `result_src`  out  2  00=alu_reg, 01=load data, 10=alu_result.
- `alu_src_a`  out  2  00=pc, 01=old_pc, 10=rd1.
- `alu_src_b`  out  2  00=rd2, 01=imm_ext, 10=4.
- `alu_control`  out  4  ALU operation.
- `imm_src`  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- `reg_write`  out  1  register file write enable.
- `instr_retired`  out  1  one-cycle pulse when an instruction completes.
- `illegal`  out  1  sticky flag: an unsupported opcode or funct3 was decoded.
- `state`  out  4  current state encoding, for debug.

## Operation
- Moore FSM with 16 states. Strobes are decoded from the registered state, plus `funct3`/`funct7b5` for the ALU operation. Any strobe not listed for a state is 0; don't-care selects are driven 0.
- ALU encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010.
- FETCH: adr_src=0, ir_write=1, a=00, b=10, ADD, result_src=10, pc_write=1. Next state is DECODE.
- DECODE: a=01, b=01, ADD. imm_src=J when the opcode is JAL, otherwise B. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH; funct3 of 010 or 011 → TRAP instead
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → TRAP
- MEMADR: a=10, b=01, ADD. imm_src=I for a load, S for a store. Next state is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: adr_src=1, result_src=00. Next state is MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state is FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Next state is FETCH.
- EXECUTER: a=10, b=00. ALU operation from funct3, with funct7b5 selecting SUB or SRA. Next state is ALUWB.
- EXECUTEI: a=10, b=01, imm I. funct7b5 is honoured only when funct3=101. Next state is ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state is FETCH.
- BRANCH: a=10, b=00, SUB, result_src=00. pc_write is set only when the branch is taken:
  - beq: zero
  - bne: !zero
  - blt: sign^overflow
  - bge: !(sign^overflow)
  - bltu: !carry
  - bgeu: carry
  - Next state is FETCH.
- JAL: a=01, b=10, ADD, result_src=00, pc_write=1. Next state is ALUWB.
- JALR: a=10, b=01, imm I, ADD. Next state is JALR_LINK.
- JALR_LINK: a=01, b=10, ADD, result_src=00, pc_write=1. Next state is ALUWB. Target bit 0 is not masked.
- LUI: b=01, imm U, PASSB. Next state is ALUWB.
- AUIPC: a=01, b=01, imm U, ADD. Next state is ALUWB.
- TRAP: all strobes 0, `illegal`=1. The FSM stays in TRAP until reset.
- `instr_retired` pulses on every transition into FETCH except the one out of reset.

## Timing
- While `reset` is low: state=FETCH, every output is 0 (including `illegal` and `instr_retired`), `state`=0.
- The first FETCH strobes appear in the cycle after `reset` rises.
- Cycles per instruction:
  - load 5, store 4
  - R-type and I-type ALU 4
  - branch 3, taken or not
  - JAL 4, JALR 5
  - LUI and AUIPC 4
- `opcode` and `funct*` are sampled from DECODE onward. They are stable because `ir_write` is asserted only in FETCH.
- Reset asserted mid-instruction drops all strobes immediately. No partial write is guaranteed beyond the current edge.

## Structure
- Package `cpu_pkg` holds:
  - the state enum (4 bits, FETCH=0)
  - ALU operation constants
  - imm_src, alu_src_a/b and result_src encodings
  - opcode constants
- Sub-module `alu_decoder` is combinational. It maps {state class, funct3, funct7b5} to `alu_control`.
- Whole block is 200–300 lines.

## Test plan
- Reset low for 3 cycles, then release. Outputs are 0 during reset; the next cycle shows pc_write=1, ir_write=1, b=10, ADD.
- Opcode 0000011 (lw): state sequence 0,DECODE,MEMADR,MEMREAD,MEMWB,0. reg_write=1 with result_src=01 only in MEMWB. `instr_retired` pulses once.
- Opcode 0110011, funct3=000, funct7b5=1: EXECUTER drives SUB. The same instruction with funct7b5=0 drives ADD. Write-back occurs in cycle 4.
- Opcode 1100011, funct3=100 (blt):
  - sign=1, overflow=0 → pc_write=1 in BRANCH.
  - sign=1, overflow=1 → pc_write=0.
  - funct3=110 with carry=0 → taken.
- Opcode 1100111 (jalr): 5 cycles. pc_write=1 in JALR_LINK with a=01, b=10. reg_write=1 in ALUWB.
- Opcode 1111111: FSM enters TRAP and `illegal`=1 with strobes held at 0 for 20 cycles. Reset low clears `illegal` and returns state to FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared encodings for the multicycle RV32I control path
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTER  = 4'd6,
    S_EXECUTEI  = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  // Selects how the ALU operation is chosen in the current state
  typedef enum logic [2:0] {
    ALU_CLS_ADD   = 3'd0,
    ALU_CLS_SUB   = 3'd1,
    ALU_CLS_PASSB = 3'd2,
    ALU_CLS_RTYPE = 3'd3,
    ALU_CLS_ITYPE = 3'd4
  } alu_class_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUREG = 2'b00;
  localparam logic [1:0] RES_LOAD   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Branch outcome from the flags of rs1 - rs2; carry set means rs1 >= rs2 unsigned
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic carry, input logic sign,
                                        input logic overflow);
    logic taken;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = sign ^ overflow;
      3'b101:  taken = !(sign ^ overflow);
      3'b110:  taken = !carry;
      3'b111:  taken = carry;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// multicycle_control_if : instruction fields / ALU flags in, datapath strobes out
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       carry;
  logic       sign;
  logic       overflow;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;
  logic [2:0] imm_src;
  logic       reg_write;
  logic       instr_retired;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, funct7b5, zero, carry, sign, overflow,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_control, imm_src, reg_write, instr_retired, illegal, state
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, carry, sign, overflow,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_control, imm_src, reg_write, instr_retired, illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// alu_decoder : maps {state class, funct3, funct7b5} to the ALU operation
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import cpu_pkg::*;
(
  input  alu_class_t i_alu_class,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_control
);

  logic alt_w;

  always_comb begin
    o_alu_control = ALU_ADD;
    alt_w         = 1'b0;
    case (i_alu_class)
      ALU_CLS_SUB:   o_alu_control = ALU_SUB;
      ALU_CLS_PASSB: o_alu_control = ALU_PASSB;
      ALU_CLS_RTYPE, ALU_CLS_ITYPE: begin
        // Immediate forms have no SUB; funct7b5 only distinguishes SRAI from SRLI
        alt_w = (i_alu_class == ALU_CLS_RTYPE) ? i_funct7b5
                                               : (i_funct7b5 && (i_funct3 == 3'b101));
        case (i_funct3)
          3'b000:  o_alu_control = alt_w ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control = ALU_SLL;
          3'b010:  o_alu_control = ALU_SLT;
          3'b011:  o_alu_control = ALU_SLTU;
          3'b100:  o_alu_control = ALU_XOR;
          3'b101:  o_alu_control = alt_w ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_control = ALU_OR;
          default: o_alu_control = ALU_AND;
        endcase
      end
      default:       o_alu_control = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : Moore control FSM sequencing the multicycle RV32I datapath
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_t     state_q, state_d;
  logic       active_q, active_d;
  logic       retired_q, retired_d;
  logic       illegal_q, illegal_d;
  alu_class_t alu_class_w;
  logic [3:0] alu_ctrl_w;

  // active_q keeps strobes low until the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      active_q  <= 1'b0;
      retired_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = 1'b1;
    if (active_q) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXECUTER;
            OP_ITYPE:          state_d = S_EXECUTEI;
            OP_BRANCH:         state_d = (bus.funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            OP_AUIPC:          state_d = S_AUIPC;
            default:           state_d = S_TRAP;
          endcase
        end
        S_MEMADR:    state_d = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:   state_d = S_MEMWB;
        S_MEMWB:     state_d = S_FETCH;
        S_MEMWRITE:  state_d = S_FETCH;
        S_EXECUTER:  state_d = S_ALUWB;
        S_EXECUTEI:  state_d = S_ALUWB;
        S_ALUWB:     state_d = S_FETCH;
        S_BRANCH:    state_d = S_FETCH;
        S_JAL:       state_d = S_ALUWB;
        S_JALR:      state_d = S_JALR_LINK;
        S_JALR_LINK: state_d = S_ALUWB;
        S_LUI:       state_d = S_ALUWB;
        S_AUIPC:     state_d = S_ALUWB;
        default:     state_d = S_TRAP;
      endcase
    end
    retired_d = active_q && (state_d == S_FETCH) && (state_q != S_FETCH);
    illegal_d = illegal_q || (active_q && (state_d == S_TRAP));
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.result_src = RES_ALUREG;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RD2;
    bus.imm_src    = IMM_I;
    bus.reg_write  = 1'b0;
    alu_class_w    = ALU_CLS_ADD;
    if (active_q) begin
      case (state_q)
        S_FETCH: begin
          bus.ir_write   = 1'b1;
          bus.alu_src_b  = SRCB_FOUR;
          bus.result_src = RES_ALU;
          bus.pc_write   = 1'b1;
        end
        S_DECODE: begin
          bus.alu_src_a = SRCA_OLDPC;
          bus.alu_src_b = SRCB_IMM;
          bus.imm_src   = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
        end
        S_MEMADR: begin
          bus.alu_src_a = SRCA_RD1;
          bus.alu_src_b = SRCB_IMM;
          bus.imm_src   = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD:  bus.adr_src = 1'b1;
        S_MEMWB: begin
          bus.result_src = RES_LOAD;
          bus.reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          bus.adr_src   = 1'b1;
          bus.mem_write = 1'b1;
        end
        S_EXECUTER: begin
          bus.alu_src_a = SRCA_RD1;
          alu_class_w   = ALU_CLS_RTYPE;
        end
        S_EXECUTEI: begin
          bus.alu_src_a = SRCA_RD1;
          bus.alu_src_b = SRCB_IMM;
          alu_class_w   = ALU_CLS_ITYPE;
        end
        S_ALUWB:    bus.reg_write = 1'b1;
        S_BRANCH: begin
          bus.alu_src_a = SRCA_RD1;
          alu_class_w   = ALU_CLS_SUB;
          bus.pc_write  = branch_taken(bus.funct3, bus.zero, bus.carry, bus.sign,
                                       bus.overflow);
        end
        S_JAL, S_JALR_LINK: begin
          // PC takes the target latched in alu_reg while the ALU forms old_pc + 4
          bus.alu_src_a = SRCA_OLDPC;
          bus.alu_src_b = SRCB_FOUR;
          bus.pc_write  = 1'b1;
        end
        S_JALR: begin
          bus.alu_src_a = SRCA_RD1;
          bus.alu_src_b = SRCB_IMM;
        end
        S_LUI: begin
          bus.alu_src_b = SRCB_IMM;
          bus.imm_src   = IMM_U;
          alu_class_w   = ALU_CLS_PASSB;
        end
        S_AUIPC: begin
          bus.alu_src_a = SRCA_OLDPC;
          bus.alu_src_b = SRCB_IMM;
          bus.imm_src   = IMM_U;
        end
        default: ;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .i_alu_class   (alu_class_w),
    .i_funct3      (bus.funct3),
    .i_funct7b5    (bus.funct7b5),
    .o_alu_control (alu_ctrl_w)
  );

  assign bus.alu_control   = alu_ctrl_w;
  assign bus.instr_retired = retired_q;
  assign bus.illegal       = illegal_q;
  assign bus.state         = state_q;

endmodule
`default_nettype wire
